fifo_stream_reader: RTL and testbench

//  Read-side master for the synchronous FIFO. Pops words via rd_en/dout/empty and presents them on a

---
 rtl/fifo_stream_reader.sv | 101 ++++++++++
 tb/tb_fifo_stream_reader.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: read-side master for a synchronous FIFO.
// Pops words with a 1-cycle read latency and re-presents them on a
// valid/ready stream through a 2-entry skid buffer. Reads are issued only
// when a buffer slot is guaranteed free on arrival, so the stream never
// loses or duplicates a word under backpressure.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            buf_level,
    output logic [CNT_WIDTH-1:0]  xfer_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } level_t;

    level_t                  state;
    logic                    infl;   // a read was issued last cycle; its data is on fifo_dout now
    logic [DATA_WIDTH-1:0]   tail;   // second entry; m_data itself is the head entry
    logic                    pop;
    logic                    push;
    logic [2:0]              occ;    // slots committed after this cycle's pop

    assign pop       = m_valid & m_ready;
    assign push      = infl;
    assign buf_level = state;

    // Credit check: buffered + in-flight - leaving must stay below 2, so a
    // word arriving next cycle always finds a free slot.
    always_comb begin
        occ        = {1'b0, state} + {2'b00, infl} - {2'b00, pop};
        fifo_rd_en = ~rst & en & ~fifo_empty & (occ < 3'd2);
    end

    // Skid buffer occupancy FSM with registered head/valid and handshake counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            infl     <= 1'b0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            tail     <= '0;
            xfer_cnt <= '0;
        end else begin
            infl <= fifo_rd_en;
            if (pop)
                xfer_cnt <= xfer_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            case (state)
                EMPTY: begin
                    // No bypass: an arriving word becomes visible next cycle.
                    if (push) begin
                        m_data  <= fifo_dout;
                        m_valid <= 1'b1;
                        state   <= ONE;
                    end
                end
                ONE: begin
                    case ({push, pop})
                        2'b10: begin
                            tail  <= fifo_dout;
                            state <= TWO;
                        end
                        2'b01: begin
                            m_valid <= 1'b0;
                            state   <= EMPTY;
                        end
                        2'b11: m_data <= fifo_dout;
                        default: ;
                    endcase
                end
                TWO: begin
                    // push without pop cannot occur here thanks to the credit check.
                    if (pop) begin
                        m_data <= tail;
                        if (push)
                            tail <= fifo_dout;
                        else
                            state <= ONE;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    m_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader: a queue-backed FIFO model feeds the
// DUT, stimulus pushes expected words, and a negedge monitor pops and compares.
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        fifo_rd_en;
    logic [15:0] fifo_dout = '0;
    logic        fifo_empty = 1'b1;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic [1:0]  buf_level;
    logic [3:0]  xfer_cnt;

    fifo_stream_reader #(.DATA_WIDTH(16), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .en(en),
        .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .buf_level(buf_level), .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [15:0] fq[$];        // FIFO contents
    logic [15:0] exp_q[$];     // scoreboard
    int          rd_cyc_q[$];  // cycles with rd_en
    int          pop_cyc_q[$]; // cycles with a stream handshake
    logic [3:0]  exp_cnt = '0;
    bit          prev_hold = 1'b0;
    logic [15:0] prev_data = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // FIFO model: data appears on fifo_dout the cycle after rd_en.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            rd_cyc_q.push_back(cyc);
            chk("rd_en_while_empty", {31'd0, fifo_empty}, 32'd0);
            if (fq.size() != 0)
                fifo_dout <= fq.pop_front();
        end
        fifo_empty <= (fq.size() == 0);
    end

    // Monitor: compares every handshake against the scoreboard.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            exp_cnt   = '0;
            prev_hold = 1'b0;
        end else begin
            chk("level_le2", {31'd0, buf_level <= 2'd2}, 32'd1);
            chk("xfer_cnt", {28'd0, xfer_cnt}, {28'd0, exp_cnt});
            if (prev_hold) begin
                chk("hold_valid", {31'd0, m_valid}, 32'd1);
                chk("hold_data", {16'd0, m_data}, {16'd0, prev_data});
            end
            if (m_valid && m_ready) begin
                pop_cyc_q.push_back(cyc);
                if (exp_q.size() == 0)
                    chk("unexpected_word", {16'd0, m_data}, 32'hFFFF_FFFF);
                else
                    chk("m_data", {16'd0, m_data}, {16'd0, exp_q.pop_front()});
                exp_cnt = exp_cnt + 4'd1;
            end
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input int n, input logic [15:0] base, input bit expect_out);
        for (int i = 0; i < n; i++) begin
            fq.push_back(base + 16'(i));
            if (expect_out) exp_q.push_back(base + 16'(i));
        end
    endtask

    task automatic drain(input int lim);
        int k = 0;
        while ((exp_q.size() != 0 || m_valid) && k < lim) begin
            step(1);
            k++;
        end
        if (k >= lim) chk("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic clr_logs();
        rd_cyc_q.delete();
        pop_cyc_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; en = 1'b0; m_ready = 1'b0;
        step(3);
        chk("rst_m_valid", {31'd0, m_valid}, 0);
        chk("rst_level", {30'd0, buf_level}, 0);
        chk("rst_cnt", {28'd0, xfer_cnt}, 0);
        chk("rst_m_data", {16'd0, m_data}, 0);
        chk("rst_rd_en", {31'd0, fifo_rd_en}, 0);
        rst = 1'b0;

        // 1: eight words at full rate
        clr_logs();
        m_ready = 1'b1;
        load(8, 16'h0001, 1'b1);
        en = 1'b1;
        drain(40);
        chk("t1_rd_count", rd_cyc_q.size(), 8);
        chk("t1_pop_count", pop_cyc_q.size(), 8);
        if (rd_cyc_q.size() == 8 && pop_cyc_q.size() == 8) begin
            chk("t1_rd_span", rd_cyc_q[7] - rd_cyc_q[0], 7);
            chk("t1_latency", pop_cyc_q[0] - rd_cyc_q[0], 2);
            chk("t1_pop_span", pop_cyc_q[7] - pop_cyc_q[0], 7);
        end
        chk("t1_xfer_cnt", {28'd0, xfer_cnt}, 8);

        // 2: backpressure holds exactly two words
        clr_logs();
        m_ready = 1'b0;
        load(5, 16'h0100, 1'b1);
        step(8);
        chk("t2_rd_count", rd_cyc_q.size(), 2);
        chk("t2_level", {30'd0, buf_level}, 2);
        chk("t2_m_valid", {31'd0, m_valid}, 1);
        chk("t2_head", {16'd0, m_data}, 32'h0100);
        m_ready = 1'b1;
        drain(40);
        chk("t2_pop_count", pop_cyc_q.size(), 5);
        if (pop_cyc_q.size() == 5)
            chk("t2_no_gap", pop_cyc_q[4] - pop_cyc_q[0], 4);

        // 3: toggling ready over 16 words
        clr_logs();
        load(16, 16'h0200, 1'b1);
        begin
            int k = 0;
            while ((exp_q.size() != 0 || m_valid) && k < 200) begin
                m_ready = ~m_ready;
                step(1);
                k++;
            end
            if (k >= 200) chk("t3_timeout", exp_q.size(), 0);
        end
        m_ready = 1'b1;
        chk("t3_pop_count", pop_cyc_q.size(), 16);

        // 4: en dropped right after a single read
        en = 1'b0;
        clr_logs();
        load(4, 16'h0300, 1'b0);
        step(3);
        chk("t4_no_rd_when_off", rd_cyc_q.size(), 0);
        exp_q.push_back(16'h0300);
        en = 1'b1;
        step(1);
        en = 1'b0;
        step(6);
        chk("t4_rd_count", rd_cyc_q.size(), 1);
        chk("t4_word_out", exp_q.size(), 0);
        chk("t4_m_valid", {31'd0, m_valid}, 0);
        for (int i = 1; i < 4; i++) exp_q.push_back(16'h0300 + 16'(i));
        en = 1'b1;
        drain(40);
        chk("t4_rd_total", rd_cyc_q.size(), 4);

        // 5: reset mid-stream discards buffered and in-flight words
        load(10, 16'h0400, 1'b1);
        step(4);
        rst = 1'b1;
        fq.delete();
        #1;
        chk("t5_rd_en_in_rst", {31'd0, fifo_rd_en}, 0);
        step(1);
        chk("t5_m_valid", {31'd0, m_valid}, 0);
        chk("t5_level", {30'd0, buf_level}, 0);
        chk("t5_cnt", {28'd0, xfer_cnt}, 0);
        chk("t5_m_data", {16'd0, m_data}, 0);
        step(1);
        rst = 1'b0;
        step(5);
        chk("t5_nothing_out", {31'd0, m_valid}, 0);

        // 6: counter wrap with 4-bit width
        load(14, 16'h0500, 1'b1);
        drain(60);
        chk("t6_cnt14", {28'd0, xfer_cnt}, 14);
        load(3, 16'h0600, 1'b1);
        drain(40);
        chk("t6_cnt_wrap", {28'd0, xfer_cnt}, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
